// File: rtl/stopwatch_pkg.sv
// Shared types and helpers for the BCD stopwatch engine.
//   state_t   : control states of the stopwatch
//   BCD_BITS  : bits per BCD digit
//   BCD_MAX   : largest legal BCD digit value
//   clamp_bcd : saturates an out-of-range nibble to BCD_MAX
package stopwatch_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUNNING = 2'd1,
    PAUSED  = 2'd2,
    EXPIRED = 2'd3
  } state_t;

  localparam int unsigned BCD_BITS = 4;
  localparam int unsigned BCD_MAX  = 9;

  // Nibbles A..F are not BCD; treat them as 9.
  function automatic logic [BCD_BITS-1:0] clamp_bcd(input logic [BCD_BITS-1:0] d);
    return (d > BCD_BITS'(BCD_MAX)) ? BCD_BITS'(BCD_MAX) : d;
  endfunction

endpackage

// File: rtl/bcd_digit.sv
// One BCD digit of the stopwatch count with ripple carry/borrow.
// Ports:
//   clk, rst_n     : clock, synchronous active-low reset
//   clr            : zero the digit
//   ld, ld_value   : load a preset (clamped to 9)
//   step_en        : a count step is taking place this cycle
//   up_down        : 1 = increment, 0 = decrement
//   carry_in       : lower digits ripple into this one (tie 1 on the LSD)
//   digit          : current digit value
//   carry_out      : this digit rolls 9 -> 0 when stepped up
//   borrow_out     : this digit rolls 0 -> 9 when stepped down
module bcd_digit
  import stopwatch_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic                clr,
  input  logic                ld,
  input  logic [BCD_BITS-1:0] ld_value,
  input  logic                step_en,
  input  logic                up_down,
  input  logic                carry_in,
  output logic [BCD_BITS-1:0] digit,
  output logic                carry_out,
  output logic                borrow_out
);

  logic [BCD_BITS-1:0] r_digit;

  // Digit register: clear > load > step.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_digit <= '0;
    end else if (clr) begin
      r_digit <= '0;
    end else if (ld) begin
      r_digit <= clamp_bcd(ld_value);
    end else if (step_en && carry_in) begin
      if (up_down) begin
        r_digit <= (r_digit == BCD_BITS'(BCD_MAX)) ? '0 : BCD_BITS'(r_digit + 1'b1);
      end else begin
        r_digit <= (r_digit == '0) ? BCD_BITS'(BCD_MAX) : BCD_BITS'(r_digit - 1'b1);
      end
    end
  end

  assign digit      = r_digit;
  assign carry_out  = carry_in & (r_digit == BCD_BITS'(BCD_MAX));
  assign borrow_out = carry_in & (r_digit == '0);

endmodule

// File: rtl/stopwatch_core.sv
// BCD stopwatch/timer engine: prescaled tick, run/pause/expire control,
// countdown to zero, lap hold and parallel load.
// Ports:
//   clk, rst_n  : clock, synchronous active-low reset
//   start_stop  : pulse, toggle run/pause (restart from EXPIRED only counting up)
//   clear       : pulse, zero count and go IDLE
//   load        : pulse, load clamped load_value and go IDLE
//   load_value  : packed BCD preset
//   up_down     : count direction, used at each tick
//   lap         : pulse, freeze/unfreeze the displayed number
//   count       : live BCD count
//   number      : display value (count or held lap)
//   running     : state is RUNNING
//   lap_hold    : number shows the held lap
//   expired     : state is EXPIRED
//   wrap        : pulse, count rolled from all-9s to 0
//   tick        : prescaler pulse (RUNNING only)
module stopwatch_core
  import stopwatch_pkg::*;
#(
  parameter int unsigned NUMBER_OF_DIGITS            = 4,
  parameter int unsigned BOARD_CLOCK_FREQUENCY_IN_HZ = 100_000_000,
  parameter int unsigned TICK_FREQUENCY_IN_HZ        = 100
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 start_stop,
  input  logic                                 clear,
  input  logic                                 load,
  input  logic [BCD_BITS*NUMBER_OF_DIGITS-1:0] load_value,
  input  logic                                 up_down,
  input  logic                                 lap,
  output logic [BCD_BITS*NUMBER_OF_DIGITS-1:0] count,
  output logic [BCD_BITS*NUMBER_OF_DIGITS-1:0] number,
  output logic                                 running,
  output logic                                 lap_hold,
  output logic                                 expired,
  output logic                                 wrap,
  output logic                                 tick
);

  localparam int unsigned W   = BCD_BITS * NUMBER_OF_DIGITS;
  localparam int unsigned DIV = BOARD_CLOCK_FREQUENCY_IN_HZ / TICK_FREQUENCY_IN_HZ;
  localparam int unsigned PW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [PW-1:0] PS_LAST = PW'(DIV - 1);

  state_t                r_state, w_state_next;
  logic [PW-1:0]         r_presc, w_presc_next;
  logic [W-1:0]          r_lap;
  logic                  r_lap_hold;
  logic                  r_wrap;

  logic [W-1:0]          w_count;
  logic                  w_tick;
  logic                  w_upper_zero;
  logic                  w_count_zero;
  logic                  w_down_to_zero;
  logic                  w_step_en;
  logic                  w_wrap;
  logic                  w_lap_ok;
  logic [NUMBER_OF_DIGITS:0]   w_ripple;
  logic [NUMBER_OF_DIGITS-1:0] w_carry;
  logic [NUMBER_OF_DIGITS-1:0] w_borrow;

  assign w_tick = (r_state == RUNNING) && (r_presc == PS_LAST);

  // All digits above the LSD are zero.
  always_comb begin
    w_upper_zero = 1'b1;
    for (int i = 1; i < int'(NUMBER_OF_DIGITS); i++) begin
      if (w_count[i*BCD_BITS +: BCD_BITS] != '0) w_upper_zero = 1'b0;
    end
  end

  assign w_count_zero   = w_upper_zero && (w_count[BCD_BITS-1:0] == '0);
  // A down tick from 1 or 0 lands on 0 and expires the timer.
  assign w_down_to_zero = w_tick && !up_down && w_upper_zero &&
                          (w_count[BCD_BITS-1:0] <= BCD_BITS'(1));
  // Never borrow below zero.
  assign w_step_en      = w_tick && (up_down || !w_count_zero);
  assign w_wrap         = w_step_en && up_down && w_ripple[NUMBER_OF_DIGITS];

  // Digit chain; the ripple signal is carry when counting up, borrow when down.
  assign w_ripple[0] = 1'b1;
  for (genvar g = 0; g < int'(NUMBER_OF_DIGITS); g++) begin : g_digit
    bcd_digit u_digit (
      .clk        (clk),
      .rst_n      (rst_n),
      .clr        (clear),
      .ld         (load && !clear),
      .ld_value   (load_value[g*BCD_BITS +: BCD_BITS]),
      .step_en    (w_step_en),
      .up_down    (up_down),
      .carry_in   (w_ripple[g]),
      .digit      (w_count[g*BCD_BITS +: BCD_BITS]),
      .carry_out  (w_carry[g]),
      .borrow_out (w_borrow[g])
    );
    assign w_ripple[g+1] = up_down ? w_carry[g] : w_borrow[g];
  end

  // State and prescaler registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_presc <= '0;
    end else begin
      r_state <= w_state_next;
      r_presc <= w_presc_next;
    end
  end

  // Next state and prescaler; expiry takes precedence over a coincident pause.
  always_comb begin
    w_state_next = r_state;
    w_presc_next = r_presc;
    if (clear || load) begin
      w_state_next = IDLE;
      w_presc_next = '0;
    end else begin
      case (r_state)
        IDLE: begin
          w_presc_next = '0;
          if (start_stop) w_state_next = RUNNING;
        end
        RUNNING: begin
          w_presc_next = w_tick ? '0 : PW'(r_presc + 1'b1);
          if (w_down_to_zero) w_state_next = EXPIRED;
          else if (start_stop) w_state_next = PAUSED;
        end
        PAUSED: begin
          if (start_stop) w_state_next = RUNNING;
        end
        EXPIRED: begin
          w_presc_next = '0;
          if (start_stop && up_down) w_state_next = RUNNING;
        end
        default: begin
          w_state_next = IDLE;
          w_presc_next = '0;
        end
      endcase
    end
  end

  // Lap only acts in an otherwise command-free cycle while counting or paused.
  assign w_lap_ok = lap && !start_stop && ((r_state == RUNNING) || (r_state == PAUSED));

  // Lap register, lap hold flag and wrap pulse.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_lap      <= '0;
      r_lap_hold <= 1'b0;
      r_wrap     <= 1'b0;
    end else begin
      r_wrap <= w_wrap && !clear && !load;
      if (clear || load) begin
        r_lap_hold <= 1'b0;
      end else if (w_lap_ok) begin
        if (r_lap_hold) begin
          r_lap_hold <= 1'b0;
        end else begin
          r_lap      <= w_count;
          r_lap_hold <= 1'b1;
        end
      end
    end
  end

  assign count    = w_count;
  assign number   = r_lap_hold ? r_lap : w_count;
  assign running  = (r_state == RUNNING);
  assign expired  = (r_state == EXPIRED);
  assign lap_hold = r_lap_hold;
  assign wrap     = r_wrap;
  assign tick     = w_tick;

endmodule

// File: doc/stopwatch_core.md
Name: stopwatch_core

Overview:
Parametrised BCD stopwatch/timer engine, the next generation of the board's fixed 4-digit up/down counter path. It adds several features: an internal tick prescaler, run/pause/expire control, countdown-to-zero with an expiry flag, lap capture and parallel load. It sits between the debounced, edge-detected button controller and the digit display/LED drivers. It presents a packed BCD number, one nibble per digit.

Parameters:
NUMBER_OF_DIGITS, 4, BCD digits in the count (1..8)
BOARD_CLOCK_FREQUENCY_IN_HZ, 100_000_000, clk frequency
TICK_FREQUENCY_IN_HZ, 100, count rate; DIV = BOARD/TICK; DIV must be an integer >= 2

Ports:
clk  input  1  board clock
rst_n  input  1  synchronous, active-low reset
start_stop  input  1  one-cycle pulse: toggle run/pause
clear  input  1  one-cycle pulse: zero count, go IDLE
load  input  1  one-cycle pulse: load load_value, go IDLE
load_value  input  4*NUMBER_OF_DIGITS  packed BCD preset
up_down  input  1  1 = count up, 0 = count down; sampled every tick
lap  input  1  one-cycle pulse: freeze/unfreeze lap display
count  output  4*NUMBER_OF_DIGITS  live BCD count
number  output  4*NUMBER_OF_DIGITS  display value (count or held lap)
running  output  1  high in RUNNING
lap_hold  output  1  high while number shows the held lap
expired  output  1  high in EXPIRED
wrap  output  1  one-cycle pulse when count wraps all-9s -> 0
tick  output  1  one-cycle prescaler pulse (RUNNING only)

Behaviour:
- Reset (rst_n low at a clk edge):
  - count = 0, lap register = 0, prescaler = 0.
  - State IDLE.
  - All 1-bit outputs low.
  - number = count.
- States:
  - IDLE: start_stop -> RUNNING.
  - RUNNING: start_stop -> PAUSED; down-count reaching 0 -> EXPIRED.
  - PAUSED: start_stop -> RUNNING.
  - EXPIRED: start_stop -> RUNNING only if up_down = 1; otherwise it is ignored.
- Command priority in one cycle: rst_n > clear > load > start_stop > lap.
  - clear: count = 0, prescaler = 0, lap_hold = 0, state IDLE.
  - load: count = load_value, with any nibble > 9 clamped to 9; prescaler = 0; lap_hold = 0; state IDLE.
- Prescaler:
  - Counts 0..DIV-1 only in RUNNING.
  - tick is high in the cycle the prescaler equals DIV-1; the prescaler returns to 0 in that cycle.
  - PAUSED holds the prescaler value, so the fractional tick is kept.
  - IDLE and EXPIRED hold the prescaler at 0.
- Count update:
  - On tick, count steps by one LSD with ripple carry/borrow across digits, all in one cycle.
  - The update is registered: the new count is visible the cycle after tick.
- Up wrap: all digits 9 plus one tick -> all 0, wrap high for that single cycle, keep RUNNING.
- Down to zero:
  - A tick taking count to 0 sets state EXPIRED in the same edge; expired is high from the next cycle.
  - Starting in RUNNING at count 0 with up_down = 0: the first tick moves straight to EXPIRED, with no borrow to all-9s.
  - Count never goes below 0.
- start_stop and tick in the same cycle while RUNNING: the tick's step is applied and the state goes PAUSED.
- Lap:
  - In RUNNING or PAUSED, a lap pulse with lap_hold = 0 captures count into the lap register and sets lap_hold = 1.
  - A lap pulse with lap_hold = 1 clears lap_hold.
  - lap is ignored in IDLE and EXPIRED.
  - number = lap_hold ? lap register : count.
- up_down may change at any time; it takes effect on the next tick.
- Reset mid-count overrides every other input.

Decomposition:
- Package stopwatch_pkg holds:
  - state enum {IDLE, RUNNING, PAUSED, EXPIRED};
  - BCD_BITS = 4 and BCD_MAX = 9;
  - a clamp_bcd function.
- Sub-module bcd_digit: one digit with inputs step_en, up_down, carry_in; outputs digit, carry_out (up: 9 -> 0) and borrow_out (down: 0 -> 9).
  - It is instantiated NUMBER_OF_DIGITS times by generate.
  - The core's EXPIRED check suppresses the borrow at all-zero.

Test Plan:
- Bench parameters for all scenarios: BOARD=20, TICK=2 (DIV=10), 4 digits.
1. Reset, then start_stop pulse, up_down=1, run 35 cycles -> tick every 10th cycle; count = 0x0003; running = 1.
2. load 0x9998, start up, 2 ticks -> count 0x9999 then 0x0000; wrap high exactly 1 cycle; state stays RUNNING.
3. load 0x0002, start down, 2 ticks -> count 0x0001, 0x0000; expired = 1; further cycles do not change count; start_stop with up_down=0 is ignored.
4. Running up at 0x0041, lap pulse -> number frozen at 0x0041 while count advances; second lap pulse -> number == count.
5. Pause at prescaler = 6, wait 50 cycles, resume -> next tick 3 cycles after resume; start_stop coincident with tick -> count still steps, state PAUSED.
6. load 0x0FA3 -> count 0x0993 (clamped); clear and load in the same cycle -> count 0; rst_n low mid-run -> all outputs 0 on the next edge.
